prog_freq_divider: RTL and testbench

Multi-channel programmable frequency divider for clock-enable and tick generation. It replaces the single-channel 16-bit load/count-down divider with NCH independent channels of parametrised width. Each channel has its own enable, pulse or 50%-duty square output mode, and glitch-free shadow reload via a valid/ready load port. It feeds timers, baud ticks and display scanning in the rest of the design.

---
 rtl/fdiv_pkg.sv | 24 ++
 rtl/fdiv_channel.sv | 138 +++++++++++++
 rtl/prog_freq_divider.sv | 61 ++++++
 tb/tb_prog_freq_divider.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared types for the programmable frequency divider.
//   fdiv_mode_e   - output mode of a channel (pulse or 50% square).
//   fdiv_shadow_t - deferred reload record (divisor + mode) held per channel.
//   fdiv_cw()     - channel-select width, never below 1 bit.
// The shadow record is sized for FDIV_MAX_W; channel WIDTH must not exceed it.
package fdiv_pkg;

    localparam int FDIV_MAX_W = 32;

    typedef enum logic {
        FDIV_PULSE  = 1'b0,
        FDIV_SQUARE = 1'b1
    } fdiv_mode_e;

    typedef struct packed {
        logic [FDIV_MAX_W-1:0] div;
        fdiv_mode_e            mode;
    } fdiv_shadow_t;

    function automatic int fdiv_cw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/fdiv_channel.sv
// fdiv_channel: one divider channel (down-counter, shadow reload, output stage).
// Optional feature macro: FDIV_SQUARE_EN (square mode, sq flop and mode storage).
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   en        - count enable; low freezes the phase exactly
//   sync      - restart the count phase (loses to an immediate load)
//   ld_we     - load strobe, already qualified by the top's handshake
//   ld_div    - new divisor (0 halts)
//   ld_mode   - new mode (ignored in the pulse-only build)
//   pending   - a deferred reload is waiting for the next terminal count
//   tc        - registered one-cycle terminal-count pulse
//   out       - divided output (tc in pulse mode, sq in square mode)
module fdiv_channel
    import fdiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             ld_we,
    input  logic [WIDTH-1:0] ld_div,
    input  logic             ld_mode,
    output logic             pending,
    output logic             tc,
    output logic             out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic             running;
    logic             run_en;
    logic             imm_ld;
    logic             def_ld;
    logic             tc_evt;
    logic             sh_zero;
    logic [WIDTH-1:0] sh_div;

    assign running = (div_act != '0);
    assign run_en  = running && en;
    // A load lands immediately unless the channel is actively counting;
    // otherwise it waits in the shadow so the current period is not cut short.
    assign imm_ld  = ld_we && !run_en;
    assign def_ld  = ld_we && run_en;
    assign tc_evt  = !imm_ld && !sync && run_en && (cnt == '0);

`ifdef FDIV_SQUARE_EN
    fdiv_shadow_t shadow;
    fdiv_mode_e   mode_act;
    logic         sq;

    // The zero test reads the full record width so no shadow bit is dead.
    assign sh_zero = (shadow.div == '0);
    assign sh_div  = WIDTH'(shadow.div);
    assign out     = (mode_act == FDIV_SQUARE) ? sq : tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow   <= '0;
            mode_act <= FDIV_PULSE;
            sq       <= 1'b0;
        end else begin
            if (def_ld)
                shadow <= '{div: FDIV_MAX_W'(ld_div), mode: fdiv_mode_e'(ld_mode)};
            if (imm_ld) begin
                mode_act <= fdiv_mode_e'(ld_mode);
                sq       <= 1'b0;
            end else if (sync) begin
                sq <= 1'b0;
            end else if (tc_evt) begin
                if (pending) begin
                    mode_act <= shadow.mode;
                    // A deferred halt must leave the output low.
                    sq       <= !sh_zero && !sq;
                end else begin
                    sq <= !sq;
                end
            end
        end
    end
`else
    logic [WIDTH-1:0] shadow_div;
    logic             unused_mode;

    assign unused_mode = ld_mode;
    assign sh_zero     = (shadow_div == '0);
    assign sh_div      = shadow_div;
    assign out         = tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            shadow_div <= '0;
        else if (def_ld)
            shadow_div <= ld_div;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            div_act <= '0;
            pending <= 1'b0;
            tc      <= 1'b0;
        end else if (imm_ld) begin
            // These equal the sync restart values, so a colliding sync is moot.
            div_act <= ld_div;
            cnt     <= (ld_div == '0) ? '0 : ld_div - ONE;
            tc      <= 1'b0;
        end else begin
            if (def_ld)
                pending <= 1'b1;
            if (sync) begin
                cnt <= running ? div_act - ONE : '0;
                tc  <= 1'b0;
            end else if (run_en) begin
                if (cnt == '0) begin
                    tc <= 1'b1;
                    if (pending) begin
                        div_act <= sh_div;
                        cnt     <= sh_zero ? '0 : sh_div - ONE;
                        pending <= 1'b0;
                    end else begin
                        cnt <= div_act - ONE;
                    end
                end else begin
                    cnt <= cnt - ONE;
                    tc  <= 1'b0;
                end
            end else begin
                tc <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prog_freq_divider.sv
// prog_freq_divider: NCH-channel programmable clock-enable / tick divider.
// Optional feature macro: FDIV_SQUARE_EN (enables 50% square output mode).
// Parameters: WIDTH (divisor width, <= FDIV_MAX_W), NCH (channels, >= 1).
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   en[NCH], sync[NCH]  - per-channel count enable / phase restart
//   ld_valid, ld_ch,
//   ld_div, ld_mode     - load request (divisor 0 halts the channel)
//   ld_ready            - combinational; request accepted when both high
//   tc[NCH], out[NCH]   - registered terminal-count pulses and divided outputs
module prog_freq_divider
    import fdiv_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 2,
    localparam int CW    = fdiv_cw(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   sync,
    input  logic             ld_valid,
    input  logic [CW-1:0]    ld_ch,
    input  logic [WIDTH-1:0] ld_div,
    input  logic             ld_mode,
    output logic             ld_ready,
    output logic [NCH-1:0]   tc,
    output logic [NCH-1:0]   out
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] ld_we;

    // Selects beyond NCH-1 match no channel, so they read ready and are dropped.
    always_comb begin
        ld_ready = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (ld_ch == CW'(i))
                ld_ready = !pending[i];
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ld_we[i] = ld_valid && (ld_ch == CW'(i)) && !pending[i];

        fdiv_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync[i]),
            .ld_we   (ld_we[i]),
            .ld_div  (ld_div),
            .ld_mode (ld_mode),
            .pending (pending[i]),
            .tc      (tc[i]),
            .out     (out[i])
        );
    end

endmodule

// File: tb/tb_prog_freq_divider.sv
// tb_prog_freq_divider: directed and random checks of prog_freq_divider
// (WIDTH=8, NCH=3) against a phase-counting reference model. Square-mode
// expectations follow FDIV_SQUARE_EN.
module tb_prog_freq_divider;

    localparam int W   = 8;
    localparam int NCH = 3;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic [NCH-1:0] sync;
    logic           ld_valid;
    logic [CW-1:0]  ld_ch;
    logic [W-1:0]   ld_div;
    logic           ld_mode;
    logic           ld_ready;
    logic [NCH-1:0] tc;
    logic [NCH-1:0] out;

    int errors = 0;
    int checks = 0;

    prog_freq_divider #(.WIDTH(W), .NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .ld_valid (ld_valid),
        .ld_ch    (ld_ch),
        .ld_div   (ld_div),
        .ld_mode  (ld_mode),
        .ld_ready (ld_ready),
        .tc       (tc),
        .out      (out)
    );

    always #5 clk = ~clk;

    // Reference model: period length, cycles elapsed in the current period,
    // a one-deep reload queue, and the output levels.
    int mdiv[NCH];
    int mph[NCH];
    int mshd[NCH];
    bit mpend[NCH];
    bit mshm[NCH];
    bit mmode[NCH];
    bit msq[NCH];
    bit mtc[NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mdiv[c] = 0; mph[c] = 0; mshd[c] = 0; mpend[c] = 0;
            mshm[c] = 0; mmode[c] = 0; msq[c] = 0; mtc[c] = 0;
        end
    endtask

    function automatic bit model_ready();
        if (int'(ld_ch) >= NCH) return 1'b1;
        return !mpend[ld_ch];
    endfunction

    task automatic model_step();
        bit acc;
        bit mine;
        bit pend_old;
        acc = ld_valid && (int'(ld_ch) < NCH) && !mpend[ld_ch];
        for (int c = 0; c < NCH; c++) begin
            mine     = acc && (int'(ld_ch) == c);
            pend_old = mpend[c];
            if (mine && (mdiv[c] == 0 || !en[c])) begin
                mdiv[c] = int'(ld_div); mmode[c] = ld_mode;
                mph[c] = 0; msq[c] = 0; mtc[c] = 0;
            end else begin
                if (mine) begin
                    mshd[c] = int'(ld_div); mshm[c] = ld_mode; mpend[c] = 1;
                end
                if (sync[c]) begin
                    mph[c] = 0; msq[c] = 0; mtc[c] = 0;
                end else if (mdiv[c] != 0 && en[c]) begin
                    if (mph[c] == mdiv[c] - 1) begin
                        mtc[c] = 1; msq[c] = !msq[c]; mph[c] = 0;
                        if (pend_old) begin
                            mdiv[c] = mshd[c]; mmode[c] = mshm[c]; mpend[c] = 0;
                            if (mshd[c] == 0) msq[c] = 0;
                        end
                    end else begin
                        mph[c]++; mtc[c] = 0;
                    end
                end else begin
                    mtc[c] = 0;
                end
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_tc();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = mtc[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) begin
`ifdef FDIV_SQUARE_EN
            v[c] = mmode[c] ? msq[c] : mtc[c];
`else
            v[c] = mtc[c];
`endif
        end
        return v;
    endfunction

    // One clock: ready is checked before the edge, outputs 1 time unit after.
    task automatic cycle();
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, model_ready()});
        model_step();
        @(posedge clk);
        #1;
        chk("tc", {29'b0, tc}, {29'b0, exp_tc()});
        chk("out", {29'b0, out}, {29'b0, exp_out()});
    endtask

    task automatic load(input int ch, input int d, input bit m);
        ld_valid = 1'b1; ld_ch = CW'(ch); ld_div = W'(d); ld_mode = m;
        cycle();
        ld_valid = 1'b0;
    endtask

    task automatic wait_tc(input int ch, input int lim, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tc[ch] && n < lim);
        if (!tc[ch]) chk("tc_timeout", {31'b0, tc[ch]}, 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b0; en = '0; sync = '0;
        ld_valid = 1'b0; ld_ch = '0; ld_div = '0; ld_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tc", {29'b0, tc}, 32'd0);
        chk("rst_out", {29'b0, out}, 32'd0);
        chk("rst_ready", {31'b0, ld_ready}, 32'd1);
        rst = 1'b1;

        // Enabled but never loaded: stays halted.
        en = '1;
        repeat (8) cycle();
        chk("halted_tc", {29'b0, tc}, 32'd0);

        // Pulse mode, D=6.
        load(0, 6, 1'b0);
        wait_tc(0, 20, n);
        chk("pulse_first", n, 6);
        chk("pulse_out_eq_tc", {31'b0, out[0]}, 32'd1);
        wait_tc(0, 20, n);
        chk("pulse_period", n, 6);

        // Square mode on ch1, D=3.
        load(1, 3, 1'b1);
        for (int j = 0; j < 12; j++) begin
`ifdef FDIV_SQUARE_EN
            chk("square_out1", {31'b0, out[1]}, (j / 3) % 2);
`else
            chk("pulse_only_out1", {31'b0, out[1]}, (j > 0 && j % 3 == 0) ? 1 : 0);
`endif
            cycle();
        end

        // Reload: D=4 running, deferred D=2, then a stalled second load of 7.
        en[0] = 1'b0;
        load(0, 4, 1'b0);
        en[0] = 1'b1;
        wait_tc(0, 20, n);
        chk("reload_p4_first", n, 4);
        ld_valid = 1'b1; ld_ch = 0; ld_div = 2; ld_mode = 1'b0;
        cycle();
        ld_div = 7;
        chk("reload_ready_low", {31'b0, ld_ready}, 32'd0);
        wait_tc(0, 20, n);
        chk("reload_p4_done", n, 3);
        chk("reload_ready_back", {31'b0, ld_ready}, 32'd1);
        cycle();
        ld_valid = 1'b0;
        chk("reload2_ready_low", {31'b0, ld_ready}, 32'd0);
        wait_tc(0, 20, n);
        chk("reload_p2", n, 1);
        wait_tc(0, 20, n);
        chk("reload_p7", n, 7);

        // en stall of 5 cycles, then sync restart.
        en[0] = 1'b0;
        load(0, 4, 1'b0);
        en[0] = 1'b1;
        wait_tc(0, 20, n);
        chk("stall_base", n, 4);
        cycle();
        en[0] = 1'b0;
        repeat (5) cycle();
        en[0] = 1'b1;
        wait_tc(0, 20, n);
        chk("stall_period", n + 6, 9);
        cycle();
        cycle();
        sync[0] = 1'b1;
        cycle();
        sync[0] = 1'b0;
        wait_tc(0, 20, n);
        chk("sync_period", n, 4);

        // D=1: tc every cycle.
        load(2, 1, 1'b0);
        repeat (4) begin
            cycle();
            chk("d1_tc", {31'b0, tc[2]}, 32'd1);
        end

        // Largest divisor.
        en[2] = 1'b0;
        load(2, 255, 1'b0);
        en[2] = 1'b1;
        wait_tc(2, 300, n);
        chk("dmax_first", n, 255);
        wait_tc(2, 300, n);
        chk("dmax_period", n, 255);

        // Deferred D=0 halts ch0 at its next terminal count.
        load(0, 0, 1'b0);
        wait_tc(0, 10, n);
        repeat (6) begin
            cycle();
            chk("halt_tc0", {31'b0, tc[0]}, 32'd0);
            chk("halt_out0", {31'b0, out[0]}, 32'd0);
        end
        chk("halt_ready", {31'b0, ld_ready}, 32'd1);

        // Out-of-range channel select is ready and dropped.
        ld_valid = 1'b1; ld_ch = 2'd3; ld_div = 5;
        chk("bad_ch_ready", {31'b0, ld_ready}, 32'd1);
        cycle();
        ld_valid = 1'b0;
        repeat (4) cycle();
        chk("bad_ch_no_tc0", {31'b0, tc[0]}, 32'd0);

        // Random traffic against the model.
        repeat (600) begin
            for (int c = 0; c < NCH; c++) begin
                en[c]   = ($urandom_range(0, 3) != 0);
                sync[c] = ($urandom_range(0, 15) == 0);
            end
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_ch    = CW'($urandom_range(0, 3));
            ld_div   = W'($urandom_range(0, 9));
            ld_mode  = 1'($urandom_range(0, 1));
            cycle();
        end

        // Asynchronous reset mid-count.
        en = '1; sync = '0; ld_valid = 1'b0; ld_ch = '0;
        load(1, 3, 1'b0);
        repeat (5) cycle();
        #2 rst = 1'b0;
        #1;
        chk("arst_tc", {29'b0, tc}, 32'd0);
        chk("arst_out", {29'b0, out}, 32'd0);
        chk("arst_ready", {31'b0, ld_ready}, 32'd1);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) cycle();
        chk("post_rst_halted", {29'b0, tc}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
